// File: rtl/sort_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sort_collector
//  Purpose  : Downstream stage of the fixed/float sorter. Captures each sorted
//             frame of M words from the sorter output stream into a two-bank
//             ping-pong buffer and replays it over a valid/ready interface
//             with a last marker, so a back-pressuring consumer can drain one
//             frame while the next one is captured.
//  Optional : ORDER_CHECK_EN - when defined, each frame is checked for
//             ascending sign-magnitude order and m_frame_err flags frames that
//             contain a violation. When undefined m_frame_err is tied low and
//             none of the checking logic exists.
//  Ports    : clock        in   1   single clock, posedge
//             rst          in   1   asynchronous active-low reset
//             in_data      in   N   sorted word (sorter outP)
//             in_valid     in   1   word strobe (sorter outvalid), no backpressure
//             m_data       out  N   replayed word
//             m_valid      out  1   m_data valid
//             m_ready      in   1   consumer accepts m_data
//             m_last       out  1   high with the M-th word of a frame
//             m_frame_err  out  1   frame held an order violation
//             ovf          out  1   sticky, at least one whole frame dropped
//             frames_out   out  16  frames fully delivered, wraps
//  Revision : 1.0 - initial release
// ============================================================================
module sort_collector #(
    parameter int M = 8,
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic [N-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic         m_frame_err,
    output logic         ovf,
    output logic [15:0]  frames_out
);

    localparam int               c_CW     = (M > 1) ? $clog2(M) : 1;
    localparam logic [c_CW-1:0]  c_LAST   = c_CW'(M - 1);
    localparam logic [c_CW-1:0]  c_ZERO   = '0;
    localparam logic [0:0]       c_R_IDLE = 1'b0;
    localparam logic [0:0]       c_R_SEND = 1'b1;

    // Two frame banks; contents need no reset because every read is gated
    // by a full flag that only a complete write can set.
    logic [N-1:0]    r_mem [2][M];
    logic [1:0]      r_full;
    logic [1:0]      w_full_nxt;

    // Write side
    logic            r_wr_bank;
    logic [c_CW-1:0] r_wr_cnt;
    logic            r_drop;       // current frame was rejected at its start
    logic            r_ovf;

    // Read side
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic            r_rd_bank;
    logic            w_rd_bank_nxt;
    logic [c_CW-1:0] r_rd_cnt;
    logic [c_CW-1:0] w_rd_cnt_nxt;
    logic [15:0]     r_frames;

    logic            w_xfer;
    logic            w_free;
    logic            w_start;
    logic            w_start_ok;
    logic            w_wr_en;
    logic            w_wr_done;
    logic            w_reject;

    // ------------------------------------------------------------------------
    // Handshake and write-acceptance decode
    // ------------------------------------------------------------------------
    assign w_xfer    = (r_state == c_R_SEND) & m_ready;
    assign w_free    = w_xfer & (r_rd_cnt == c_LAST);
    assign w_start   = in_valid & (r_wr_cnt == c_ZERO);
    // A bank freed by the final transfer this cycle can take the first word
    // of the next frame in the same cycle.
    assign w_start_ok = ~r_full[r_wr_bank] | (w_free & (r_rd_bank == r_wr_bank));
    assign w_wr_en   = in_valid & (w_start ? w_start_ok : ~r_drop);
    assign w_wr_done = w_wr_en & (r_wr_cnt == c_LAST);
    assign w_reject  = w_start & ~w_start_ok;

    always_comb begin
        w_full_nxt = r_full;
        if (w_free) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_wr_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Write side registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_drop    <= 1'b0;
            r_ovf     <= 1'b0;
            r_full    <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
            // Rejected frames are still counted so the next frame boundary
            // stays aligned with the sorter output.
            if (in_valid) begin
                r_wr_cnt <= (r_wr_cnt == c_LAST) ? '0 : r_wr_cnt + c_CW'(1);
            end
            if (w_start) begin
                r_drop <= ~w_start_ok;
            end
            if (w_reject) begin
                r_ovf <= 1'b1;
            end
            if (w_wr_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_bank][r_wr_cnt] <= in_data;
        end
    end

    // ------------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_rd_cnt_nxt  = r_rd_cnt;
        w_rd_bank_nxt = r_rd_bank;
        case (r_state)
            c_R_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_rd_cnt_nxt = '0;
                    w_state_nxt  = c_R_SEND;
                end
            end
            c_R_SEND: begin
                if (w_xfer) begin
                    if (r_rd_cnt == c_LAST) begin
                        w_rd_bank_nxt = ~r_rd_bank;
                        w_state_nxt   = c_R_IDLE;
                    end else begin
                        w_rd_cnt_nxt = r_rd_cnt + c_CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = c_R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state   <= c_R_IDLE;
            r_rd_cnt  <= '0;
            r_rd_bank <= 1'b0;
            r_frames  <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_cnt  <= w_rd_cnt_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            if (w_free) begin
                r_frames <= r_frames + 16'd1;
            end
        end
    end

    // Data path outputs are gated by m_valid so every output reads zero as
    // soon as reset asserts, without resetting the bank storage.
    assign m_valid    = (r_state == c_R_SEND);
    assign m_data     = m_valid ? r_mem[r_rd_bank][r_rd_cnt] : '0;
    assign m_last     = m_valid & (r_rd_cnt == c_LAST);
    assign ovf        = r_ovf;
    assign frames_out = r_frames;

`ifdef ORDER_CHECK_EN
    // ------------------------------------------------------------------------
    // Ascending sign-magnitude order check
    // ------------------------------------------------------------------------
    logic [N-1:0] r_prev;
    logic         r_werr;      // violation seen so far in the frame being written
    logic [1:0]   r_err;       // per-bank frame error, travels with the full flag
    logic         w_word_lt;

    // True when a < b in sign-magnitude. Negative beats positive (so -0 < +0);
    // among negatives the larger magnitude is the smaller value.
    function automatic logic f_lt(input logic [N-1:0] a, input logic [N-1:0] b);
        logic r;
        if (a[N-1] != b[N-1]) begin
            r = a[N-1];
        end else if (!a[N-1]) begin
            r = (a[N-2:0] < b[N-2:0]);
        end else begin
            r = (a[N-2:0] > b[N-2:0]);
        end
        return r;
    endfunction

    assign w_word_lt = (r_wr_cnt != c_ZERO) & f_lt(in_data, r_prev);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_prev <= '0;
            r_werr <= 1'b0;
            r_err  <= 2'b00;
        end else if (w_wr_en) begin
            r_prev <= in_data;
            r_werr <= (r_wr_cnt == c_ZERO) ? 1'b0 : (r_werr | w_word_lt);
            if (w_wr_done) begin
                r_err[r_wr_bank] <= r_werr | w_word_lt;
            end
        end
    end

    assign m_frame_err = m_valid & r_err[r_rd_bank];
`else
    assign m_frame_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sort_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sort_collector
//  Purpose  : Self-checking bench for sort_collector. A frame-level model
//             (queue of captured frames with availability timestamps) predicts
//             every output each cycle; directed literal checks pin the model.
//             Honours ORDER_CHECK_EN the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sort_collector;

    localparam int M = 8;
    localparam int N = 32;
`ifdef ORDER_CHECK_EN
    localparam bit c_ORDER_ON = 1'b1;
`else
    localparam bit c_ORDER_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic [N-1:0]  m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic          m_frame_err;
    logic          ovf;
    logic [15:0]   frames_out;

    sort_collector #(.M(M), .N(N)) dut (
        .clock       (clock),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .m_frame_err (m_frame_err),
        .ovf         (ovf),
        .frames_out  (frames_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Frame-level model
    // ------------------------------------------------------------------------
    logic [M*N-1:0] q_data [$];
    bit             q_err  [$];
    int             q_avail[$];
    int             beat = 0;
    int             last_done = -100;
    bit             exp_ovf = 0;
    logic [15:0]    exp_frames = '0;
    int             wcnt = 0;
    bit             wacc = 0;
    logic [M*N-1:0] wbuf = '0;
    bit             ev;
    int             st;

    // Ordering key: doubles the magnitude and maps negatives below zero so
    // that -0 sits just under +0.
    function automatic longint key(input logic [N-1:0] x);
        longint mag;
        mag = longint'(x[N-2:0]);
        return x[N-1] ? -(2 * mag + 1) : 2 * mag;
    endfunction

    function automatic bit frame_err(input logic [M*N-1:0] f);
        bit e;
        e = 0;
        for (int i = 1; i < M; i++)
            if (key(f[i*N +: N]) < key(f[(i-1)*N +: N])) e = 1;
        return e;
    endfunction

    always @(negedge clock) begin
        if (!rst) begin
            q_data.delete(); q_err.delete(); q_avail.delete();
            beat = 0; last_done = -100; exp_ovf = 0; exp_frames = '0;
            wcnt = 0; wacc = 0;
            chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
            chk("rst_m_data", m_data, 32'd0);
        end else begin
            ev = 0;
            if (q_data.size() > 0) begin
                st = (q_avail[0] > last_done + 2) ? q_avail[0] : last_done + 2;
                ev = (cyc >= st);
            end
            chk("m_valid", {31'd0, m_valid}, {31'd0, ev});
            if (ev) begin
                chk("m_data", m_data, q_data[0][beat*N +: N]);
                chk("m_last", {31'd0, m_last}, {31'd0, (beat == M-1)});
                chk("m_frame_err", {31'd0, m_frame_err}, {31'd0, q_err[0]});
            end
            chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
            chk("frames_out", {16'd0, frames_out}, {16'd0, exp_frames});
            if (ev && m_ready) begin
                beat++;
                if (beat == M) begin
                    void'(q_data.pop_front()); void'(q_err.pop_front()); void'(q_avail.pop_front());
                    exp_frames = exp_frames + 16'd1;
                    last_done = cyc;
                    beat = 0;
                end
            end
            if (in_valid) begin
                if (wcnt == 0) begin
                    wacc = (q_data.size() < 2);
                    if (!wacc) exp_ovf = 1;
                end
                wbuf[wcnt*N +: N] = in_data;
                wcnt++;
                if (wcnt == M) begin
                    if (wacc) begin
                        q_data.push_back(wbuf);
                        q_err.push_back(c_ORDER_ON && frame_err(wbuf));
                        q_avail.push_back(cyc + 2);
                    end
                    wcnt = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    function automatic logic [M*N-1:0] mk(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    task automatic word(input logic [N-1:0] d);
        @(posedge clock); #1;
        in_valid = 1'b1;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [M*N-1:0] f, output int t_last);
        for (int i = 0; i < M; i++) word(f[i*N +: N]);
        t_last = cyc;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clock);
        #1 rst = 1'b1;
    endtask

    task automatic wait_valid(input string name, output int t_seen);
        bit got;
        got = 0;
        t_seen = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (m_valid) begin
                got = 1;
                t_seen = cyc;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: m_valid never rose, required within 40 cycles", name);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int t_last;
    int t_seen;
    int nx;

    initial begin
        // Reset state
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        chk("reset_frames", {16'd0, frames_out}, 32'd0);
        rst = 1'b1;
        idle(2);

        // Basic frame 1..8
        send_frame(mk(1, 2, 3, 4, 5, 6, 7, 8), t_last);
        idle(1);
        wait_valid("t1_latency", t_seen);
        chk("t1_latency", t_seen, t_last + 2);
        chk("t1_first_word", m_data, 32'd1);
        idle(12);
        chk("t1_frames", {16'd0, frames_out}, 32'd1);

        // Out-of-order frame
        send_frame(mk(5, 3, 9, 10, 11, 12, 13, 14), t_last);
        idle(1);
        wait_valid("t2_valid", t_seen);
        chk("t2_err", {31'd0, m_frame_err}, {31'd0, c_ORDER_ON});
        idle(12);

        // Signed ordering, correct then with first two swapped
        send_frame(mk(32'h80000005, 32'h80000001, 32'h80000000, 32'h00000000,
                      32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005), t_last);
        idle(1);
        wait_valid("t3a_valid", t_seen);
        chk("t3a_err", {31'd0, m_frame_err}, 32'd0);
        idle(12);
        send_frame(mk(32'h80000001, 32'h80000005, 32'h80000000, 32'h00000000,
                      32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005), t_last);
        idle(1);
        wait_valid("t3b_valid", t_seen);
        chk("t3b_err", {31'd0, m_frame_err}, {31'd0, c_ORDER_ON});
        idle(12);

        // Three back-to-back frames while stalled: A, B held, C dropped
        do_reset();
        m_ready = 1'b0;
        send_frame(mk(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7), t_last);
        send_frame(mk(32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7), t_last);
        send_frame(mk(32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5, 32'hC6, 32'hC7), t_last);
        idle(3);
        chk("t4_ovf", {31'd0, ovf}, 32'd1);
        chk("t4_held_word", m_data, 32'hA0);
        chk("t4_frames_before", {16'd0, frames_out}, 32'd0);
        m_ready = 1'b1;
        idle(30);
        chk("t4_frames_after", {16'd0, frames_out}, 32'd2);

        // Random back-pressure
        fork
            begin
                repeat (180) begin
                    @(posedge clock); #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int f = 0; f < 5; f++) begin
                    for (int i = 0; i < M; i++) word(32'h1000 + 32'(f * 16 + i));
                    idle(10);
                end
            end
        join
        m_ready = 1'b1;
        idle(30);

        // Reset mid-drain at beat 4
        send_frame(mk(11, 12, 13, 14, 15, 16, 17, 18), t_last);
        idle(1);
        nx = 0;
        for (int i = 0; i < 40 && nx < 4; i++) begin
            @(negedge clock);
            if (m_valid && m_ready) nx++;
        end
        @(posedge clock); #2;
        rst = 1'b0;
        #1;
        chk("t6_valid", {31'd0, m_valid}, 32'd0);
        chk("t6_data", m_data, 32'd0);
        chk("t6_last", {31'd0, m_last}, 32'd0);
        chk("t6_frames", {16'd0, frames_out}, 32'd0);
        repeat (2) @(posedge clock);
        #1 rst = 1'b1;
        send_frame(mk(32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27, 32'h28), t_last);
        idle(1);
        wait_valid("t6_valid_after", t_seen);
        chk("t6_first_after", m_data, 32'h21);
        idle(12);
        chk("t6_frames_after", {16'd0, frames_out}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
